// File: rtl/fc_pkg.sv
// Shared types and helpers for the multi-channel frequency counter.
// Holds the gate FSM encoding and the saturating edge increment.
package fc_pkg;

    typedef enum logic {
        FC_IDLE = 1'b0,
        FC_RUN  = 1'b1
    } fc_state_e;

    localparam int unsigned FC_MAX_W = 64;

    function automatic logic [FC_MAX_W-1:0] sat_inc(
        input logic [FC_MAX_W-1:0] cnt,
        input logic                inc,
        input int unsigned         width
    );
        logic [FC_MAX_W-1:0] max_v;
        max_v = (64'd1 << width) - 64'd1;
        if (inc && (cnt != max_v)) begin
            return cnt + 64'd1;
        end
        return cnt;
    endfunction

endpackage

// File: rtl/freq_counter_multi_if.sv
// Host-side bus of the frequency counter: channel inputs, control
// pulses and latched results.
interface freq_counter_multi_if #(
    parameter int NCH    = 4,
    parameter int CNT_W  = 32,
    parameter int GATE_W = 26
);
    logic [NCH-1:0]       sig_i;
    logic [NCH-1:0]       edge_sel_i;
    logic [GATE_W-1:0]    gate_len_i;
    logic                 continuous_i;
    logic                 start_i;
    logic                 stop_i;
    logic                 busy_o;
    logic                 valid_o;
    logic [NCH*CNT_W-1:0] count_o;
    logic [NCH-1:0]       ovf_o;

    modport master (
        output sig_i, edge_sel_i, gate_len_i,
        output continuous_i, start_i, stop_i,
        input  busy_o, valid_o, count_o, ovf_o
    );

    modport slave (
        input  sig_i, edge_sel_i, gate_len_i,
        input  continuous_i, start_i, stop_i,
        output busy_o, valid_o, count_o, ovf_o
    );
endinterface

// File: rtl/fc_edge_chan.sv
// One counter channel: input synchroniser, edge detect, saturating
// edge counter and sticky overflow flag for the current window.
module fc_edge_chan
    import fc_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             slowclock,
    input  logic             reset,
    input  logic             sig_i,
    input  logic             edge_sel_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_nxt_o,
    output logic             ovf_nxt_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic                   sync_s;
    logic                   edge_hit;
    logic [CNT_W-1:0]       cnt_sum;

    assign sync_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], sig_i};
        // prev tracks every cycle so entering RUN never sees a stale edge
        prev_d   = sync_s;
        edge_hit = (sync_s & ~prev_q) | (edge_sel_i & (sync_s ^ prev_q));
        cnt_sum  = CNT_W'(sat_inc(64'(cnt_q), edge_hit, CNT_W));
        cnt_nxt_o = cnt_sum;
        ovf_nxt_o = ovf_q | (edge_hit & (&cnt_q));
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        if (clr_i) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (en_i) begin
            cnt_d = cnt_sum;
            ovf_d = ovf_nxt_o;
        end
    end

    always_ff @(posedge slowclock) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
        end
    end

endmodule

// File: rtl/freq_counter_multi.sv
// Gate FSM, window counter and result latches for NCH edge-counting
// channels; one-shot or back-to-back continuous windows.
module freq_counter_multi
    import fc_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int CNT_W       = 32,
    parameter int GATE_W      = 26,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 slowclock,
    input  logic                 reset,
    freq_counter_multi_if.slave  fc
);

    fc_state_e                  state_q, state_d;
    logic [GATE_W-1:0]          gate_cnt_q, gate_cnt_d;
    logic                       busy_q, busy_d;
    logic                       valid_q, valid_d;
    logic [NCH*CNT_W-1:0]       count_q, count_d;
    logic [NCH-1:0]             ovf_q, ovf_d;
    logic                       chan_clr;
    logic                       chan_en;
    logic [NCH-1:0][CNT_W-1:0]  cnt_nxt;
    logic [NCH-1:0]             ovf_nxt;

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        fc_edge_chan #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_chan (
            .slowclock  (slowclock),
            .reset      (reset),
            .sig_i      (fc.sig_i[k]),
            .edge_sel_i (fc.edge_sel_i[k]),
            .clr_i      (chan_clr),
            .en_i       (chan_en),
            .cnt_nxt_o  (cnt_nxt[k]),
            .ovf_nxt_o  (ovf_nxt[k])
        );
    end

    always_comb begin
        state_d    = state_q;
        gate_cnt_d = gate_cnt_q;
        valid_d    = 1'b0;
        count_d    = count_q;
        ovf_d      = ovf_q;
        chan_clr   = 1'b0;
        chan_en    = 1'b0;
        unique case (state_q)
            FC_IDLE: begin
                if (fc.start_i && (fc.gate_len_i != '0)) begin
                    gate_cnt_d = fc.gate_len_i;
                    chan_clr   = 1'b1;
                    state_d    = FC_RUN;
                end
            end
            FC_RUN: begin
                if (fc.stop_i) begin
                    gate_cnt_d = '0;
                    chan_clr   = 1'b1;
                    state_d    = FC_IDLE;
                end else if (gate_cnt_q == GATE_W'(1)) begin
                    // final cycle's edge is folded into the latched value
                    count_d  = cnt_nxt;
                    ovf_d    = ovf_nxt;
                    valid_d  = 1'b1;
                    chan_clr = 1'b1;
                    if (fc.continuous_i && (fc.gate_len_i != '0)) begin
                        gate_cnt_d = fc.gate_len_i;
                    end else begin
                        gate_cnt_d = '0;
                        state_d    = FC_IDLE;
                    end
                end else begin
                    gate_cnt_d = gate_cnt_q - GATE_W'(1);
                    chan_en    = 1'b1;
                end
            end
            default: state_d = FC_IDLE;
        endcase
        busy_d = (state_d == FC_RUN);
    end

    always_ff @(posedge slowclock) begin
        if (reset) begin
            state_q    <= FC_IDLE;
            gate_cnt_q <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            count_q    <= '0;
            ovf_q      <= '0;
        end else begin
            state_q    <= state_d;
            gate_cnt_q <= gate_cnt_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
        end
    end

    assign fc.busy_o  = busy_q;
    assign fc.valid_o = valid_q;
    assign fc.count_o = count_q;
    assign fc.ovf_o   = ovf_q;

endmodule

// File: doc/freq_counter_multi.md
Name: freq_counter_multi

Overview:
Multi-channel, gate-programmable edge/frequency counter in the slowclock domain. It is the parametrised successor to the single-channel DUT-clock counter driven from the heartbeat divider. It counts edges on NCH asynchronous low-rate inputs (DUT trigger, prescaled DUT clock, GPIO) over a host-programmed window of slowclock cycles. Counts are latched to host-readable registers with saturation flags, in one-shot or continuous (back-to-back, no dead cycle) mode.

Parameters:
NCH, 4, number of input channels (1..16)
CNT_W, 32, per-channel edge counter width
GATE_W, 26, gate-length width in slowclock cycles
SYNC_STAGES, 2, synchroniser flops per input (>=2)

Ports:
slowclock  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high
sig_i  in  NCH  asynchronous inputs; max toggle rate slowclock/2 (after prescale)
edge_sel_i  in  NCH  per channel: 0 = rising edges only, 1 = both edges
gate_len_i  in  GATE_W  window length in cycles; 0 = disabled
continuous_i  in  1  1 = restart window automatically after each latch
start_i  in  1  one-cycle pulse; begins measurement from IDLE
stop_i  in  1  one-cycle pulse; abandons current window
busy_o  out  1  high while in RUN
valid_o  out  1  one-cycle pulse when count_o/ovf_o update
count_o  out  NCH*CNT_W  latched counts; channel k at [k*CNT_W +: CNT_W]
ovf_o  out  NCH  latched per-channel saturation flag

Behaviour:
- Reset: busy_o=0, valid_o=0, count_o=0, ovf_o=0, all counters/sync flops/prev-sample regs=0, state IDLE.
- Input path, per channel:
  - SYNC_STAGES-flop synchroniser feeds prev-sample reg.
  - edge = (sync & ~prev) | (edge_sel & (sync ^ prev)).
  - Prev reg updates every cycle in all states, so there is no spurious edge on entry to RUN.
  - Edge-to-count latency is SYNC_STAGES+1 cycles.
- States: IDLE, RUN.
- IDLE:
  - On start_i with gate_len_i!=0: gate_cnt<=gate_len_i, all cnt<=0, enter RUN.
  - start_i with gate_len_i==0 is ignored.
- RUN, when gate_cnt!=1:
  - gate_cnt decrements by 1.
  - cnt <= sat(cnt+edge).
- RUN, when gate_cnt==1 (final window cycle):
  - count_o <= sat(cnt+edge); ovf_o <= ovf_int | (cnt==max & edge).
  - valid_o=1 on the following cycle, registered together with count_o.
  - cnt<=0, ovf_int<=0.
  - If continuous_i=1 and gate_len_i!=0: gate_cnt<=gate_len_i, stay in RUN (next window starts next cycle, no dead cycle).
  - Otherwise go to IDLE.
- Window length is exactly gate_len_i cycles. gate_len_i is sampled only at window start.
- Saturation: cnt holds at 2^CNT_W-1. ovf_int sets on any edge arriving while cnt is already max.
- stop_i in RUN:
  - Enter IDLE next cycle, no valid_o, count_o/ovf_o retain previous values, internal counters cleared.
  - stop_i and gate_cnt==1 in the same cycle: stop wins, no latch.
  - stop_i in IDLE: ignored.
- start_i in RUN: ignored. start_i and stop_i together in IDLE: start is taken.
- continuous_i deasserted mid-window: the current window completes and latches, then IDLE.
- busy_o = (state==RUN), registered.
- Reset mid-window: immediate return to reset values; no valid_o.
- Frequency (Hz) = count * f_slowclock / gate_len (rising-only mode). Computed by the host, not in RTL.

Decomposition:
- Shared package fc_pkg: state encoding (FC_IDLE, FC_RUN) and the saturating-add function sat_inc(cnt, edge, width).
- Sub-module fc_edge_chan: synchroniser + edge detect + saturating counter + ovf flag, instantiated NCH times via generate.
- Top-level freq_counter_multi holds the gate FSM, gate counter and output latches.

Test Plan:
1. ch0 square wave, period 10 cycles; edge_sel=0, gate_len=100, start -> one valid_o ~101 cycles after start; count ch0=10, ovf=0; busy_o falls.
2. Same stimulus with edge_sel[0]=1, ch1 tied high, ch2 period 4 -> ch0=20, ch1=0, ch2=25.
3. CNT_W=4, ch0 period 4, gate_len=100, edge_sel=0 -> ch0=15, ovf_o[0]=1; next window with gate_len=20 -> ch0=5, ovf_o[0]=0.
4. continuous_i=1, gate_len=50, ch0 period 5 -> valid_o every 50 cycles, each ch0=10. Deassert continuous_i mid-window -> exactly one more valid_o, then busy_o=0.
5. stop_i at cycle 30 of a 100-cycle window; also stop_i coincident with final cycle -> no valid_o, count_o unchanged, busy_o=0 next cycle; fresh start_i works normally.
6. gate_len=0 + start_i -> busy_o stays 0, no valid_o. Reset asserted mid-RUN -> all outputs 0 next cycle.
